// File: rtl/npc_gen_ras.sv
// Next-PC generator for fetch with a speculative circular return-address stack.
// Optional macro NPC_RAS_RECOVER_EN restores {tp, cnt} from redirect_ckpt on a backend redirect.
module npc_gen_ras #(
  parameter int XLEN      = 64,
  parameter int RAS_DEPTH = 8,
  parameter int PTR_W     = $clog2(RAS_DEPTH),
  parameter int CNT_W     = $clog2(RAS_DEPTH) + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [XLEN-1:0]        in_pc_add4,
  input  logic                   in_hit,
  input  logic [2:0]             in_type,
  input  logic [XLEN-1:0]        in_pred_pc,
  input  logic                   in_pred_taken,
  input  logic                   out_ready,
  input  logic                   redirect_valid,
  input  logic [XLEN-1:0]        redirect_pc,
  input  logic [PTR_W+CNT_W-1:0] redirect_ckpt,
  output logic                   npc_valid,
  output logic [XLEN-1:0]        next_pc,
  output logic                   predict_taken,
  output logic                   hit,
  output logic [XLEN-1:0]        predict_pc,
  output logic [PTR_W+CNT_W-1:0] ras_ckpt,
  output logic                   ras_empty,
  output logic                   ras_full
);
  localparam logic [2:0] T_B       = 3'b001;
  localparam logic [2:0] T_JAL     = 3'b010;
  localparam logic [2:0] T_JALR    = 3'b011;
  localparam logic [2:0] T_CALL    = 3'b100;
  localparam logic [2:0] T_RET     = 3'b101;
  localparam logic [2:0] T_CALLRET = 3'b110;

  logic [XLEN-1:0]  r_entry [RAS_DEPTH];
  logic [PTR_W-1:0] r_tp;
  logic [CNT_W-1:0] r_cnt;

  logic             w_accept;
  logic             w_upd;
  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_tp_inc;
  logic [PTR_W-1:0] w_tp_dec;
  logic [XLEN-1:0]  w_top;

  assign w_accept = in_valid & out_ready & ~redirect_valid & ~rst;
  assign w_upd    = w_accept & in_hit;
  assign w_empty  = (r_cnt == '0);
  assign w_full   = (r_cnt == CNT_W'(RAS_DEPTH));
  // Depth is a power of two, so pointer arithmetic wraps for free.
  assign w_tp_inc = r_tp + PTR_W'(1);
  assign w_tp_dec = r_tp - PTR_W'(1);
  assign w_top    = r_entry[r_tp];

  assign npc_valid     = ~rst & (redirect_valid | in_valid);
  assign predict_taken = in_pred_taken;
  assign hit           = in_hit;
  assign predict_pc    = in_pred_pc;
  assign ras_empty     = w_empty;
  assign ras_full      = w_full;

`ifdef NPC_RAS_RECOVER_EN
  assign ras_ckpt = {r_tp, r_cnt};
`else
  logic w_unused_ckpt;
  assign w_unused_ckpt = ^redirect_ckpt;
  assign ras_ckpt      = '0;
`endif

  always_comb begin
    next_pc = in_pc_add4;
    if (redirect_valid) begin
      next_pc = redirect_pc;
    end else if (in_hit) begin
      case (in_type)
        T_B:                   if (in_pred_taken) next_pc = in_pred_pc;
        T_JAL, T_JALR, T_CALL: next_pc = in_pred_pc;
        T_RET, T_CALLRET:      next_pc = w_empty ? in_pred_pc : w_top;
        default:               next_pc = in_pc_add4;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_tp  <= '0;
      r_cnt <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) r_entry[i] <= '0;
    end else begin
`ifdef NPC_RAS_RECOVER_EN
      if (redirect_valid) {r_tp, r_cnt} <= redirect_ckpt;
`endif
      if (w_upd) begin
        case (in_type)
          T_CALL: begin
            // A full stack silently overwrites its oldest entry.
            r_tp              <= w_tp_inc;
            r_entry[w_tp_inc] <= in_pc_add4;
            if (!w_full) r_cnt <= r_cnt + CNT_W'(1);
          end
          T_RET: begin
            if (!w_empty) begin
              r_tp  <= w_tp_dec;
              r_cnt <= r_cnt - CNT_W'(1);
            end
          end
          T_CALLRET: begin
            if (!w_empty) begin
              r_entry[r_tp] <= in_pc_add4;
            end else begin
              r_tp              <= w_tp_inc;
              r_entry[w_tp_inc] <= in_pc_add4;
              r_cnt             <= CNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_npc_gen_ras.sv
// Bench for npc_gen_ras: directed scenarios plus random traffic against a queue-based stack model.
module tb_npc_gen_ras;
  localparam int XLEN = 64;
  localparam int D    = 8;
  localparam int PW   = 3;
  localparam int CW   = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid, in_hit, in_pred_taken, out_ready, redirect_valid;
  logic [XLEN-1:0] in_pc_add4, in_pred_pc, redirect_pc;
  logic [2:0]      in_type;
  logic [PW+CW-1:0] redirect_ckpt;
  logic            npc_valid, predict_taken, hit, ras_empty, ras_full;
  logic [XLEN-1:0] next_pc, predict_pc;
  logic [PW+CW-1:0] ras_ckpt;

  always #5 clk = ~clk;

  npc_gen_ras #(.XLEN(XLEN), .RAS_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc_add4(in_pc_add4), .in_hit(in_hit),
    .in_type(in_type), .in_pred_pc(in_pred_pc), .in_pred_taken(in_pred_taken),
    .out_ready(out_ready), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .redirect_ckpt(redirect_ckpt), .npc_valid(npc_valid), .next_pc(next_pc),
    .predict_taken(predict_taken), .hit(hit), .predict_pc(predict_pc), .ras_ckpt(ras_ckpt),
    .ras_empty(ras_empty), .ras_full(ras_full)
  );

  // Model: return addresses, oldest at front, newest at back, capped at D.
  logic [XLEN-1:0] q[$];
  int n_pass = 0;
  int n_tot  = 0;

  task automatic idle();
    in_valid = 0; in_hit = 0; in_type = 3'd0; in_pc_add4 = '0; in_pred_pc = '0;
    in_pred_taken = 0; out_ready = 1; redirect_valid = 0; redirect_pc = '0; redirect_ckpt = '0;
  endtask

  task automatic lookup(input logic [2:0] t, input logic h, input logic [XLEN-1:0] pc4,
                        input logic [XLEN-1:0] pred, input logic tk);
    in_valid = 1; in_hit = h; in_type = t; in_pc_add4 = pc4; in_pred_pc = pred; in_pred_taken = tk;
  endtask

  function automatic logic [XLEN-1:0] exp_npc();
    if (redirect_valid) return redirect_pc;
    if (!in_hit) return in_pc_add4;
    case (in_type)
      3'd1:       return in_pred_taken ? in_pred_pc : in_pc_add4;
      3'd2, 3'd3,
      3'd4:       return in_pred_pc;
      3'd5, 3'd6: return (q.size() != 0) ? q[$] : in_pred_pc;
      default:    return in_pc_add4;
    endcase
  endfunction

  // Advance the model by this cycle's inputs, then clock the DUT.
  task automatic tick();
    bit acc;
    acc = in_valid && out_ready && !redirect_valid && !rst;
    if (rst) q.delete();
    else if (acc && in_hit) begin
      case (in_type)
        3'd4: begin q.push_back(in_pc_add4); if (q.size() > D) void'(q.pop_front()); end
        3'd5: if (q.size() != 0) void'(q.pop_back());
        3'd6: if (q.size() != 0) q[q.size()-1] = in_pc_add4; else q.push_back(in_pc_add4);
        default: ;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1; idle(); lookup(3'd4, 1, 64'h44, 64'h88, 0);
    #1;
    n_tot++; if (npc_valid !== 1'b0) $display("FAIL rst_npc_valid: got %b exp 0", npc_valid); else n_pass++;
    tick(); tick();
    rst = 0; idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL rst_empty: got %b exp 1", ras_empty); else n_pass++;
    n_tot++; if (ras_full !== 1'b0) $display("FAIL rst_full: got %b exp 0", ras_full); else n_pass++;
    n_tot++; if (ras_ckpt !== '0) $display("FAIL rst_ckpt: got %h exp 0", ras_ckpt); else n_pass++;
  endtask

  task automatic test_call_ret();
    lookup(3'd4, 1, 64'h1004, 64'h2000, 0); #1;
    n_tot++; if (next_pc !== 64'h2000) $display("FAIL call_tgt: got %h exp 2000", next_pc); else n_pass++;
    n_tot++; if (npc_valid !== 1'b1) $display("FAIL call_valid: got %b exp 1", npc_valid); else n_pass++;
    tick(); idle(); #1;
    n_tot++; if (ras_empty !== 1'b0) $display("FAIL call_nonempty: got %b exp 0", ras_empty); else n_pass++;
`ifdef NPC_RAS_RECOVER_EN
    n_tot++; if (ras_ckpt !== {3'd1, 4'd1}) $display("FAIL call_ckpt: got %h exp %h", ras_ckpt, {3'd1, 4'd1}); else n_pass++;
`endif
    lookup(3'd5, 1, 64'h3004, 64'hdead, 0); #1;
    n_tot++; if (next_pc !== 64'h1004) $display("FAIL ret_tgt: got %h exp 1004", next_pc); else n_pass++;
    tick(); idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL ret_empty: got %b exp 1", ras_empty); else n_pass++;
  endtask

  task automatic test_fill();
    for (int k = 1; k <= 9; k++) begin
      lookup(3'd4, 1, 64'(k * 256), 64'h3000, 0); tick();
    end
    idle(); #1;
    n_tot++; if (ras_full !== 1'b1) $display("FAIL fill_full: got %b exp 1", ras_full); else n_pass++;
`ifdef NPC_RAS_RECOVER_EN
    n_tot++; if (ras_ckpt[CW-1:0] !== 4'd8) $display("FAIL fill_cnt: got %0d exp 8", ras_ckpt[CW-1:0]); else n_pass++;
`endif
    for (int k = 0; k < 8; k++) begin
      lookup(3'd5, 1, 64'h5000, 64'hbeef, 0); #1;
      n_tot++;
      if (next_pc !== 64'((9 - k) * 256)) $display("FAIL fill_ret%0d: got %h exp %h", k, next_pc, 64'((9 - k) * 256));
      else n_pass++;
      tick();
    end
    lookup(3'd5, 1, 64'h5000, 64'hbeef, 0); #1;
    n_tot++; if (next_pc !== 64'hbeef) $display("FAIL fill_ret_empty: got %h exp beef", next_pc); else n_pass++;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL fill_empty: got %b exp 1", ras_empty); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_call_ret_swap();
    lookup(3'd4, 1, 64'h500, 64'h600, 0); tick();
    lookup(3'd6, 1, 64'h704, 64'h9999, 0); #1;
    n_tot++; if (next_pc !== 64'h500) $display("FAIL cr_tgt: got %h exp 500", next_pc); else n_pass++;
    tick();
    lookup(3'd5, 1, 64'h10, 64'h0, 0); #1;
    n_tot++; if (next_pc !== 64'h704) $display("FAIL cr_newtop: got %h exp 704", next_pc); else n_pass++;
    tick(); idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL cr_cnt: got empty=%b exp 1", ras_empty); else n_pass++;
  endtask

  task automatic test_branch();
    lookup(3'd1, 1, 64'h40, 64'h80, 0); #1;
    n_tot++; if (next_pc !== 64'h40) $display("FAIL br_nt: got %h exp 40", next_pc); else n_pass++;
    in_pred_taken = 1; #1;
    n_tot++; if (next_pc !== 64'h80) $display("FAIL br_t: got %h exp 80", next_pc); else n_pass++;
    n_tot++; if (predict_taken !== 1'b1 || predict_pc !== 64'h80) $display("FAIL br_pass: got %b/%h exp 1/80", predict_taken, predict_pc); else n_pass++;
    lookup(3'd4, 0, 64'h40, 64'h80, 0); #1;
    n_tot++; if (next_pc !== 64'h40) $display("FAIL miss_call: got %h exp 40", next_pc); else n_pass++;
    n_tot++; if (hit !== 1'b0) $display("FAIL miss_hit: got %b exp 0", hit); else n_pass++;
    tick(); idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL miss_nopush: got %b exp 1", ras_empty); else n_pass++;
  endtask

  task automatic test_stall_reset();
    lookup(3'd4, 1, 64'h111, 64'h222, 0); tick();
    out_ready = 0;
    for (int k = 0; k < 3; k++) begin
      lookup(3'd4, 1, 64'h333, 64'h444, 0); #1;
      n_tot++; if (npc_valid !== 1'b1 || next_pc !== 64'h444) $display("FAIL stall%0d: got %b/%h exp 1/444", k, npc_valid, next_pc); else n_pass++;
      tick();
    end
    out_ready = 1;
    lookup(3'd5, 1, 64'h0, 64'h777, 0); #1;
    n_tot++; if (next_pc !== 64'h111) $display("FAIL stall_hold: got %h exp 111", next_pc); else n_pass++;
    tick(); idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL stall_cnt: got %b exp 1", ras_empty); else n_pass++;
    lookup(3'd4, 1, 64'haa0, 64'h1, 0); tick();
    lookup(3'd4, 1, 64'hbb0, 64'h1, 0); tick();
    rst = 1; lookup(3'd4, 1, 64'hcc0, 64'h1, 0); #1;
    n_tot++; if (npc_valid !== 1'b0) $display("FAIL midrst_valid: got %b exp 0", npc_valid); else n_pass++;
    tick(); rst = 0; idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL midrst_empty: got %b exp 1", ras_empty); else n_pass++;
    lookup(3'd5, 1, 64'h0, 64'habc, 0); #1;
    n_tot++; if (next_pc !== 64'habc) $display("FAIL midrst_ret: got %h exp abc", next_pc); else n_pass++;
    tick(); idle();
  endtask

  task automatic test_redirect();
`ifdef NPC_RAS_RECOVER_EN
    logic [XLEN-1:0] saved[$];
    logic [PW+CW-1:0] ck;
    lookup(3'd4, 1, 64'ha00, 64'h1, 0); tick();
    lookup(3'd4, 1, 64'hb00, 64'h1, 0); tick();
    lookup(3'd4, 1, 64'hc00, 64'h1, 0); tick();
    lookup(3'd5, 1, 64'h0, 64'h2, 0); #1;
    ck = ras_ckpt; saved = q;
    n_tot++; if (ck !== {3'd3, 4'd3}) $display("FAIL rd_ckpt: got %h exp %h", ck, {3'd3, 4'd3}); else n_pass++;
    tick();
    lookup(3'd5, 1, 64'h0, 64'h2, 0); tick();
    lookup(3'd5, 1, 64'h0, 64'h2, 0); tick();
    lookup(3'd4, 1, 64'hd00, 64'h3, 0);
    redirect_valid = 1; redirect_pc = 64'h8000; redirect_ckpt = ck; #1;
    n_tot++; if (next_pc !== 64'h8000) $display("FAIL rd_pc: got %h exp 8000", next_pc); else n_pass++;
    tick(); q = saved; idle(); #1;
    n_tot++; if (ras_ckpt !== ck) $display("FAIL rd_restore: got %h exp %h", ras_ckpt, ck); else n_pass++;
    lookup(3'd5, 1, 64'h0, 64'h2, 0); #1;
    n_tot++; if (next_pc !== 64'hc00) $display("FAIL rd_top: got %h exp c00", next_pc); else n_pass++;
    tick(); idle();
`else
    lookup(3'd4, 1, 64'ha00, 64'h1, 0); tick();
    lookup(3'd4, 1, 64'hd00, 64'h3, 0);
    redirect_valid = 1; redirect_pc = 64'h8000; redirect_ckpt = 7'h5a; #1;
    n_tot++; if (next_pc !== 64'h8000) $display("FAIL rd_pc: got %h exp 8000", next_pc); else n_pass++;
    n_tot++; if (ras_ckpt !== '0) $display("FAIL rd_ckpt0: got %h exp 0", ras_ckpt); else n_pass++;
    tick(); idle();
    lookup(3'd5, 1, 64'h0, 64'h2, 0); #1;
    n_tot++; if (next_pc !== 64'ha00) $display("FAIL rd_nopush: got %h exp a00", next_pc); else n_pass++;
    tick(); idle(); #1;
    n_tot++; if (ras_empty !== 1'b1) $display("FAIL rd_empty: got %b exp 1", ras_empty); else n_pass++;
`endif
  endtask

  task automatic test_random();
    logic [XLEN-1:0] e;
    logic            ev;
    for (int n = 0; n < 400; n++) begin
      rst            = ($urandom_range(0, 49) == 0);
      in_valid       = ($urandom_range(0, 3) != 0);
      in_hit         = ($urandom_range(0, 4) != 0);
      in_type        = 3'($urandom_range(0, 7));
      in_pc_add4     = {$urandom, $urandom};
      in_pred_pc     = {$urandom, $urandom};
      in_pred_taken  = 1'($urandom_range(0, 1));
      out_ready      = ($urandom_range(0, 4) != 0);
      redirect_valid = ($urandom_range(0, 9) == 0);
      redirect_pc    = {$urandom, $urandom};
`ifdef NPC_RAS_RECOVER_EN
      redirect_ckpt  = ras_ckpt;
`else
      redirect_ckpt  = 7'($urandom);
`endif
      #1;
      e  = exp_npc();
      ev = !rst && (redirect_valid || in_valid);
      n_tot++; if (next_pc !== e) $display("FAIL rnd%0d_npc: got %h exp %h", n, next_pc, e); else n_pass++;
      n_tot++; if (npc_valid !== ev) $display("FAIL rnd%0d_valid: got %b exp %b", n, npc_valid, ev); else n_pass++;
      n_tot++; if (ras_empty !== (q.size() == 0)) $display("FAIL rnd%0d_empty: got %b exp %b", n, ras_empty, q.size() == 0); else n_pass++;
      n_tot++; if (ras_full !== (q.size() == D)) $display("FAIL rnd%0d_full: got %b exp %b", n, ras_full, q.size() == D); else n_pass++;
      tick();
    end
    rst = 0; idle();
  endtask

  initial begin
    test_reset();
    test_call_ret();
    test_fill();
    test_call_ret_swap();
    test_branch();
    test_stall_reset();
    test_redirect();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/npc_gen_ras.md
# npc_gen_ras

Parametrised next-PC generator for the fetch stage with an integrated circular return-address stack (RAS). Each cycle it selects the next fetch PC from BTB/direction-predictor results: fall-through, predicted target, or RAS top. It maintains the RAS speculatively and, when configured, restores the stack pointer from a checkpoint on a backend redirect. It sits between the BTB/PHT read stage and the PC register.

## Interface
- XLEN, 64, address width
- RAS_DEPTH, 8, RAS entries; power of two, ≥2
- PTR_W, $clog2(RAS_DEPTH), RAS pointer width (derived)
- CNT_W, $clog2(RAS_DEPTH)+1, occupancy counter width (derived)

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- in_valid  in  1  predictor lookup result valid
- in_pc_add4  in  XLEN  fetch PC + 4
- in_hit  in  1  BTB hit
- in_type  in  3  001 B, 010 JAL, 011 JALR, 100 CALL, 101 RET, 110 CALL_RET; others are treated as no branch
- in_pred_pc  in  XLEN  BTB target
- in_pred_taken  in  1  direction prediction
- out_ready  in  1  PC register accepts next_pc
- redirect_valid  in  1  backend mispredict/flush
- redirect_pc  in  XLEN  corrected PC
- redirect_ckpt  in  PTR_W+CNT_W  checkpoint carried with the mispredicted instruction
- npc_valid  out  1  next_pc valid
- next_pc  out  XLEN  selected next PC
- predict_taken, hit  out  1  pass-through of in_pred_taken, in_hit
- predict_pc  out  XLEN  pass-through of in_pred_pc
- ras_ckpt  out  PTR_W+CNT_W  {tp, cnt} before this lookup's update
- ras_empty, ras_full  out  1  cnt==0, cnt==RAS_DEPTH

## Operation
- accept = in_valid & out_ready & ~redirect_valid & ~rst. The RAS changes only on accept or on redirect.
- Selection, in priority order:
  - redirect_valid: redirect_pc.
  - ~in_hit: in_pc_add4.
  - B: in_pred_pc if in_pred_taken, else in_pc_add4.
  - JAL/JALR/CALL: in_pred_pc.
  - RET/CALL_RET: entry[tp] if cnt≠0, else in_pred_pc.
  - Other types: in_pc_add4.
- npc_valid = ~rst & (redirect_valid | in_valid).
- State: entry[0..RAS_DEPTH-1] (XLEN), tp (PTR_W), cnt (CNT_W).
- Push on accept & in_hit & CALL: tp←tp+1 (wrap mod RAS_DEPTH); entry[tp+1]←in_pc_add4; cnt←min(cnt+1, RAS_DEPTH). When full, the push overwrites the oldest entry.
- Pop on accept & in_hit & RET: if cnt≠0, tp←tp−1 (wrap) and cnt←cnt−1. If cnt==0, no state change.
- CALL_RET on accept & in_hit: if cnt≠0, entry[tp]←in_pc_add4 with tp and cnt unchanged. If cnt==0, behaves as a push (tp←tp+1, cnt←1).
- Redirect: see Configuration. Redirect always wins over a simultaneous accept; no push or pop happens that cycle.
- Entries are never restored. A call popped then overwritten on the wrong path yields a wrong target after recovery. This is accepted and corrected by the backend.

## Timing
- next_pc, npc_valid, the pass-throughs and ras_ckpt are combinational from the inputs and the current state. Selection has zero latency.
- RAS state updates at the rising clk edge following accept. The next lookup sees the new top.
- out_ready low: outputs remain driven and the RAS holds. The upstream holds its inputs stable.
- Reset: while rst=1, npc_valid=0. On the first clock edge with rst=1: tp=0, cnt=0, all entries=0. After reset, ras_empty=1, ras_full=0, ras_ckpt=0.
- rst asserted mid-operation clears the stack on that edge and discards a simultaneous push or pop.

## Configuration
- NPC_RAS_RECOVER_EN defined: on redirect_valid, {tp, cnt}←redirect_ckpt at the clock edge.
- NPC_RAS_RECOVER_EN undefined: redirect_valid only forces next_pc and suppresses the update; tp and cnt keep their values. redirect_ckpt is ignored and ras_ckpt is driven 0.

## Test plan
- Reset, then hit CALL with in_pc_add4=0x1004 and target 0x2000 → next_pc=0x2000; next cycle cnt=1. Then hit RET with in_pred_pc=0xdead → next_pc=0x1004, ras_empty=1 afterwards.
- RAS_DEPTH=8, nine CALLs with in_pc_add4=0x100..0x900 → ras_full=1, cnt=8. Eight RETs return 0x900 down to 0x200. A ninth RET returns in_pred_pc.
- CALL_RET on stack top 0x500 with in_pc_add4=0x704 → next_pc=0x500, top becomes 0x704, cnt unchanged.
- B hit with pred_taken=0 → next_pc=in_pc_add4. Same with taken=1 → next_pc=in_pred_pc. in_hit=0 with type CALL → in_pc_add4, no push.
- (RECOVER_EN) Capture ras_ckpt at a RET, do two wrong-path RETs, then redirect with that checkpoint and redirect_pc=0x8000 → next_pc=0x8000, tp and cnt equal the checkpoint, and a simultaneous CALL is not pushed.
- out_ready=0 with a valid CALL for 3 cycles → cnt unchanged. rst pulse mid-sequence → cnt=0 and npc_valid=0 during rst.
